// File: rtl/ppu_vbuf_pkg.sv
// ppu_vbuf_pkg: shared geometry, FSM state and FIFO entry layout for the vbuf write side
package ppu_vbuf_pkg;
  localparam int H_PIX = 256;
  localparam int V_PIX = 240;
  localparam int FIFO_DEPTH = 4;
  localparam int XW = $clog2(H_PIX);
  localparam int YW = 8;
  localparam int DW = 8;
  localparam int VBUF_AW = 1 + YW + XW;
  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, FLUSH = 2'd2} state_t;
  typedef struct packed {
    logic page;
    logic [YW-1:0] y;
    logic [XW-1:0] x;
    logic [DW-1:0] data;
  } entry_t;
  function automatic logic last_x(input logic [XW-1:0] x);
    return x == XW'(H_PIX - 1);
  endfunction
  function automatic logic last_y(input logic [YW-1:0] y);
    return y == YW'(V_PIX - 1);
  endfunction
endpackage

// File: rtl/ppu_vbuf_wr_fifo.sv
// ppu_vbuf_wr_fifo: synchronous entry FIFO with registered full/empty, async active-high reset
// ports: clk, rst, push/din (write side), pop/dout (head), full, empty
module ppu_vbuf_wr_fifo
  import ppu_vbuf_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t din,
  input  logic   pop,
  output entry_t dout,
  output logic   full,
  output logic   empty
);
  localparam int AW = $clog2(DEPTH);
  entry_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt, cnt_nxt;
  logic do_push, do_pop;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign cnt_nxt = cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      full <= 1'b0;
      empty <= 1'b1;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      cnt <= cnt_nxt;
      full <= cnt_nxt == (AW+1)'(DEPTH);
      empty <= cnt_nxt == '0;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/ppu_vbuf_writer.sv
// ppu_vbuf_writer: writes the PPU pixel stream into the vbuf page not being scanned out
// ports: i_ppu_clk/i_ppu_rst; pixel stream i_pix_valid/o_pix_ready/i_pix_hsv/i_pix_sof;
//   i_rd_page scan-out page; i_clr_err clears sticky flags; vbuf write port
//   o_vbuf_addr/o_vbuf_data/o_vbuf_we/i_vbuf_gnt; status o_wr_page/o_frame_done/o_busy/o_err_sof/o_tear
module ppu_vbuf_writer
  import ppu_vbuf_pkg::*;
(
  input  logic               i_ppu_clk,
  input  logic               i_ppu_rst,
  input  logic               i_pix_valid,
  output logic               o_pix_ready,
  input  logic [7:0]         i_pix_hsv,
  input  logic               i_pix_sof,
  input  logic               i_rd_page,
  input  logic               i_clr_err,
  output logic [VBUF_AW-1:0] o_vbuf_addr,
  output logic [7:0]         o_vbuf_data,
  output logic               o_vbuf_we,
  input  logic               i_vbuf_gnt,
  output logic               o_wr_page,
  output logic               o_frame_done,
  output logic               o_busy,
  output logic               o_err_sof,
  output logic               o_tear
);
  state_t state, state_nxt;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic full, empty, accept, sof_acc, push, last_pix, err_set, tear_set;
  entry_t din, head;
  assign accept = i_pix_valid & o_pix_ready;
  assign sof_acc = accept & i_pix_sof;
  assign push = accept & (i_pix_sof | state == ACTIVE);
  assign last_pix = state == ACTIVE && last_x(x) && last_y(y);
  assign din = i_pix_sof ? '{page: ~i_rd_page, y: '0, x: '0, data: i_pix_hsv}
                         : '{page: o_wr_page, y: y, x: x, data: i_pix_hsv};
  assign err_set = sof_acc & (state == ACTIVE);
  assign tear_set = (state != IDLE) & (i_rd_page == o_wr_page);
  assign o_vbuf_addr = {head.page, head.y, head.x};
  assign o_vbuf_data = head.data;
  assign o_vbuf_we = ~empty;
  ppu_vbuf_wr_fifo u_fifo (
    .clk(i_ppu_clk),
    .rst(i_ppu_rst),
    .push(push),
    .din(din),
    .pop(o_vbuf_we & i_vbuf_gnt),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge i_ppu_clk or posedge i_ppu_rst)
    if (i_ppu_rst) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = sof_acc ? ACTIVE
              : (accept & last_pix) ? FLUSH
              : (state == FLUSH && empty) ? IDLE
              : state;
  // frame_done fires in the FLUSH cycle right after the last pop, one cycle after the final write
  always_comb begin
    o_pix_ready = state == IDLE || (state == ACTIVE && !full);
    o_busy = state != IDLE;
    o_frame_done = state == FLUSH && empty;
  end
  always_ff @(posedge i_ppu_clk or posedge i_ppu_rst)
    if (i_ppu_rst) begin
      x <= '0;
      y <= '0;
      o_wr_page <= 1'b0;
    end else if (sof_acc) begin
      x <= XW'(1);
      y <= '0;
      o_wr_page <= ~i_rd_page;
    end else if (push) begin
      x <= x + XW'(1);
      y <= !last_x(x) ? y : last_y(y) ? '0 : y + YW'(1);
    end
  always_ff @(posedge i_ppu_clk or posedge i_ppu_rst)
    if (i_ppu_rst) begin
      o_err_sof <= 1'b0;
      o_tear <= 1'b0;
    end else begin
      o_err_sof <= err_set | (o_err_sof & ~i_clr_err);
      o_tear <= tear_set | (o_tear & ~i_clr_err);
    end
endmodule

// File: tb/tb_ppu_vbuf_writer.sv
// tb_ppu_vbuf_writer: directed scoreboard bench for ppu_vbuf_writer
module tb_ppu_vbuf_writer;
  logic clk = 1'b0, rst = 1'b1;
  logic pix_valid = 1'b0, pix_sof = 1'b0, rd_page = 1'b1, clr_err = 1'b0, vbuf_gnt = 1'b1;
  logic [7:0] pix_hsv = '0;
  logic pix_ready, vbuf_we, wr_page, frame_done, busy, err_sof, tear;
  logic [16:0] vbuf_addr;
  logic [7:0] vbuf_data;
  int ncmp = 0, nerr = 0, cyc = 0;
  int wr_cnt = 0, done_cnt = 0, last_wr_cyc = 0, done_cyc = 0;
  logic [16:0] first_addr = '0, last_addr = '0;
  logic [24:0] sb [$];
  logic [24:0] exp_w;
  int mst = 0;
  logic [7:0] mx = '0, my = '0;
  logic mpage = 1'b0;

  ppu_vbuf_writer dut (
    .i_ppu_clk(clk),
    .i_ppu_rst(rst),
    .i_pix_valid(pix_valid),
    .o_pix_ready(pix_ready),
    .i_pix_hsv(pix_hsv),
    .i_pix_sof(pix_sof),
    .i_rd_page(rd_page),
    .i_clr_err(clr_err),
    .o_vbuf_addr(vbuf_addr),
    .o_vbuf_data(vbuf_data),
    .o_vbuf_we(vbuf_we),
    .i_vbuf_gnt(vbuf_gnt),
    .o_wr_page(wr_page),
    .o_frame_done(frame_done),
    .o_busy(busy),
    .o_err_sof(err_sof),
    .o_tear(tear)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst && vbuf_we && vbuf_gnt) begin
      if (wr_cnt == 0) first_addr = vbuf_addr;
      last_addr = vbuf_addr;
      last_wr_cyc = cyc;
      wr_cnt++;
      ncmp++;
      assert (sb.size() != 0) else begin
        nerr++;
        $error("FAIL unexpected_write: observed addr %h data %h, expected no write", vbuf_addr, vbuf_data);
      end
      if (sb.size() != 0) begin
        exp_w = sb.pop_front();
        ncmp++;
        assert ({vbuf_addr, vbuf_data} === exp_w) else begin
          nerr++;
          $error("FAIL write_order: observed addr %h data %h, expected addr %h data %h", vbuf_addr, vbuf_data, exp_w[24:8], exp_w[7:0]);
        end
      end
    end
    if (!rst && frame_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [7:0] d, input logic sof);
    if (sof) begin
      mpage = ~rd_page;
      sb.push_back({mpage, 8'd0, 8'd0, d});
      mx = 8'd1;
      my = 8'd0;
      mst = 1;
    end else if (mst == 1) begin
      sb.push_back({mpage, my, mx, d});
      if (mx == 8'd255) begin
        mx = 8'd0;
        if (my == 8'd239) begin
          my = 8'd0;
          mst = 2;
        end else my++;
      end else mx++;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic sof);
    int n = 0;
    pix_valid = 1'b1;
    pix_hsv = d;
    pix_sof = sof;
    while (!pix_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!pix_ready) begin
      ncmp++;
      assert (pix_ready === 1'b1) else begin
        nerr++;
        $error("FAIL ready_timeout: observed ready %b expected 1 within 100 cycles", pix_ready);
      end
    end else begin
      model(d, sof);
      @(posedge clk);
      #1;
    end
    pix_valid = 1'b0;
    pix_sof = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pix_valid = 1'b0;
    pix_sof = 1'b0;
    clr_err = 1'b0;
    sb.delete();
    mst = 0;
    wait_cycles(2);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    wait_cycles(2);
    chk("rst_we", 32'(vbuf_we), 32'(0));
    chk("rst_ready", 32'(pix_ready), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_wr_page", 32'(wr_page), 32'(0));
    chk("rst_err_tear_done", 32'({err_sof, tear, frame_done}), 32'(0));
    rst = 1'b0;

    // full frame, gnt tied high, scan-out on page 1
    rd_page = 1'b1;
    vbuf_gnt = 1'b1;
    send(8'h80 | 8'($urandom_range(0, 127)), 1'b1);
    for (int i = 1; i < 256 * 240; i++) send(8'($urandom), 1'b0);
    n = 0;
    while (busy && n < 20) begin
      wait_cycles(1);
      n++;
    end
    chk("f1_idle", 32'(busy), 32'(0));
    chk("f1_writes", 32'(wr_cnt), 32'(61440));
    chk("f1_first_addr", 32'(first_addr), 32'(17'h00000));
    chk("f1_last_addr", 32'(last_addr), 32'({1'b0, 8'd239, 8'd255}));
    chk("f1_done_cnt", 32'(done_cnt), 32'(1));
    chk("f1_done_timing", 32'(done_cyc), 32'(last_wr_cyc + 1));
    chk("f1_err_tear", 32'({err_sof, tear}), 32'(0));
    chk("f1_sb_empty", 32'(sb.size()), 32'(0));

    // backpressure: FIFO fills, head holds, then drains in order
    do_reset();
    vbuf_gnt = 1'b0;
    send(8'h11, 1'b1);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    chk("bp_ready_low", 32'(pix_ready), 32'(0));
    chk("bp_we", 32'(vbuf_we), 32'(1));
    for (int i = 0; i < 3; i++) begin
      wait_cycles(1);
      chk("bp_addr_hold", 32'(vbuf_addr), 32'(sb[0][24:8]));
      chk("bp_data_hold", 32'(vbuf_data), 32'(sb[0][7:0]));
    end
    vbuf_gnt = 1'b1;
    for (int i = 0; i < 6; i++) send(8'(8'h50 + i), 1'b0);
    wait_cycles(6);
    chk("bp_drained", 32'(sb.size()), 32'(0));
    chk("bp_busy", 32'(busy), 32'(1));

    // early SOF with entries queued, then clear
    do_reset();
    rd_page = 1'b1;
    send(8'h01, 1'b1);
    for (int i = 1; i < 3 * 256 + 8; i++) send(8'($urandom), 1'b0);
    vbuf_gnt = 1'b0;
    send(8'hA8, 1'b0);
    send(8'hA9, 1'b0);
    rd_page = 1'b0;
    send(8'hC0, 1'b1);
    chk("sof_err", 32'(err_sof), 32'(1));
    chk("sof_relatch", 32'(wr_page), 32'(1));
    chk("sof_full", 32'(pix_ready), 32'(0));
    chk("sof_tear", 32'(tear), 32'(1));
    vbuf_gnt = 1'b1;
    for (int i = 0; i < 3; i++) send(8'(8'hD0 + i), 1'b0);
    wait_cycles(4);
    chk("sof_drained", 32'(sb.size()), 32'(0));
    clr_err = 1'b1;
    wait_cycles(1);
    clr_err = 1'b0;
    chk("clr_err_sof", 32'(err_sof), 32'(0));
    chk("clr_tear", 32'(tear), 32'(0));

    // tear: scan-out moves onto the page being written
    do_reset();
    rd_page = 1'b1;
    send(8'h05, 1'b1);
    for (int i = 0; i < 19; i++) send(8'($urandom), 1'b0);
    chk("tear_clean", 32'(tear), 32'(0));
    rd_page = 1'b0;
    for (int i = 0; i < 5; i++) send(8'(8'hE0 + i), 1'b0);
    chk("tear_set", 32'(tear), 32'(1));
    chk("tear_page_kept", 32'(wr_page), 32'(0));
    wait_cycles(3);
    chk("tear_drained", 32'(sb.size()), 32'(0));

    // pixels without SOF while idle are discarded
    do_reset();
    rd_page = 1'b1;
    send(8'h71, 1'b0);
    send(8'h72, 1'b0);
    send(8'h73, 1'b0);
    wait_cycles(2);
    chk("idle_busy", 32'(busy), 32'(0));
    chk("idle_we", 32'(vbuf_we), 32'(0));
    chk("idle_sb", 32'(sb.size()), 32'(0));

    // reset with queued entries
    do_reset();
    vbuf_gnt = 1'b0;
    rd_page = 1'b0;
    send(8'h91, 1'b1);
    send(8'h92, 1'b0);
    send(8'h93, 1'b1);
    chk("pre_rst_we", 32'(vbuf_we), 32'(1));
    chk("pre_rst_err", 32'(err_sof), 32'(1));
    chk("pre_rst_page", 32'(wr_page), 32'(1));
    rst = 1'b1;
    sb.delete();
    mst = 0;
    wait_cycles(1);
    chk("mid_rst_we", 32'(vbuf_we), 32'(0));
    chk("mid_rst_ready", 32'(pix_ready), 32'(1));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_page", 32'(wr_page), 32'(0));
    chk("mid_rst_flags", 32'({err_sof, tear, frame_done}), 32'(0));
    rst = 1'b0;
    vbuf_gnt = 1'b1;
    wait_cycles(3);
    chk("post_rst_we", 32'(vbuf_we), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
